rv_prefetch: RTL and testbench
==============================

# rv_prefetch

Parametrised instruction-fetch unit for the RV32 core family. It replaces the single-word IF phase with a decoupled prefetcher. It drives the instruction `master_bus_if`, runs ahead of execution into a DEPTH-entry instruction queue, and presents {pc, instruction} pairs to the execute/decode stage through a valid/ready handshake. It also supports control-flow redirect with squash and a debug halt that quiesces only at a transaction boundary.

## Interface
- `INITIAL_PC`, 32'h0000_0000, fetch address after reset (bits [1:0] must be 0)
- `DEPTH`, 4, queue entries; power of two, ≥ 2
- `clk`  input  1  clock; all logic on rising edge
- `rst`  input  1  reset, synchronous, active-high
- `ibus`  master  master_bus_if  instruction bus; this block drives `breq`, `bstart`, `ttype`, `tsize`, `addr`, `wdata` and samples `bdone`, `rdata`
- `inst_valid`  output  1  queue head valid
- `inst_data`  output  32  instruction at head
- `inst_pc`  output  32  address of `inst_data`
- `inst_ready`  input  1  consumer accepts head this cycle
- `redirect`  input  1  one-cycle pulse: discard everything, restart fetch
- `redirect_pc`  input  32  new fetch address; bits [1:0] forced to 0
- `halt`  input  1  stop issuing new fetches while high
- `halted`  output  1  `halt` high and no transaction outstanding
- `occupancy`  output  $clog2(DEPTH)+1  current queue entry count

## Operation
- Constant bus fields: `breq`=1, `ttype`=READ, `tsize`=WORD, `wdata`=0, `addr`=`fpc`.
- At most one transaction is outstanding at a time.
- FSM states:
  - IDLE: `bstart`=0. Moves to REQ when `!halt && !redirect && occupancy < DEPTH`.
  - REQ: `bstart`=1, `addr` stable. On `bdone`, push {fpc, rdata}, `fpc`+=4, go to IDLE.
  - DROP: `bstart`=1. On `bdone`, discard the data and go to IDLE.
- The slot for an outstanding fetch is reserved at issue. A push never meets a full queue.
- Redirect rules:
  - Any state: flush the queue and set `fpc`=`redirect_pc`.
  - REQ without `bdone`: go to DROP.
  - REQ with `bdone` in the same cycle: discard the data, go to IDLE.
  - DROP: stay in DROP (the new `fpc` is still taken).
  - Redirect beats a same-cycle pop and push. The head is not consumed.
- Pop happens when `inst_valid && inst_ready`. Push and pop in the same cycle leaves occupancy unchanged.
- `fpc` wraps from 32'hFFFF_FFFC to 0 modulo 2^32. Queue pointers wrap modulo DEPTH.
- Halt:
  - `halt` never aborts an in-flight transaction.
  - `halted` = `halt && state==IDLE`, combinational.
  - The queue keeps draining while halted.

## Timing
- Reset values: state=IDLE, `fpc`=INITIAL_PC, queue empty, `bstart`=0, `inst_valid`=0, `occupancy`=0, `halted`=`halt`.
- Issue: in the first cycle after reset release with `halt`=0, the FSM enters REQ. `bstart` is high in the following cycle.
- Fetch latency: `bdone` at cycle N puts the head in the queue, so `inst_valid`=1 at N+1 (registered path).
- Back-to-back fetches: IDLE occupies one cycle between transactions. Peak rate is one instruction per (bus latency + 1) cycles.
- Redirect at cycle N: `inst_valid`=0 at N+1, and the first fetch at `redirect_pc` is requested no earlier than N+1.
- `rst` in mid-transaction: the FSM returns to IDLE immediately. The bus slave must tolerate `bstart` dropping; the system-level rule is that the bus resets on the same `rst`.

## Configuration
- `RV_PREFETCH_BYPASS_EN` defined:
  - When the queue is empty and `bdone` arrives in REQ, `{pc, rdata}` is presented on `inst_*` in the same cycle with `inst_valid`=1.
  - If `inst_ready`=1 in that cycle, nothing is pushed.
  - Redirect in the same cycle suppresses the bypass.
- Macro undefined: purely registered path, latency as in Timing.

## Structure
- Shared package `rv_core_pkg`:
  - `fetch_state_e` {IDLE, REQ, DROP}
  - `fetch_entry_t` packed struct {pc[31:0], inst[31:0]}
  - `NOP` constant 32'h0000_0013 (driven on `inst_data` when invalid)
- One sub-module, `sync_fifo #(WIDTH, DEPTH)`: synchronous flush, count output, push/pop, no overflow protection (guarded by the reservation rule).

## Test plan
- Reset, then a slave with 1-cycle `bdone` latency and INITIAL_PC=0x100, `inst_ready`=1 → `inst_pc` sequence 0x100, 0x104, 0x108 with matching `rdata`. First `inst_valid` is 3 cycles after reset release (2 with bypass).
- `inst_ready`=0, DEPTH=4 → exactly 4 transactions, `occupancy`=4, `bstart` stays 0. One pop → exactly one new fetch, at 0x110.
- Redirect to 0x2002 while in REQ with a 3-cycle slave → the old transaction completes but its data is discarded. The next `addr` is 0x2000 and the next `inst_pc` is 0x2000.
- Redirect in the same cycle as `bdone` and a pop → queue empty next cycle, no stale entry ever valid.
- `halt` raised mid-transaction → `halted`=0 until `bdone`, then 1. No further `bstart`. The queue drains normally. `halt` low → fetch resumes at the next sequential pc.
- Redirect to 0xFFFF_FFF8 → fetched pcs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.

Source files
------------

// File: rtl/rv_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_core_pkg
// Description : Shared types and constants for the RV32 instruction fetch
//               path: fetch FSM states, queue entry layout, bus encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_core_pkg;

    // Fetch engine states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    // Bus transfer type and size encodings
    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } ttype_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } tsize_e;

    // One queued instruction together with the address it came from
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // addi x0, x0, 0 - shown on the instruction output whenever nothing is valid
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Clears the byte offset so every fetch address is word aligned
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/master_bus_if.sv
`default_nettype none
// ============================================================================
// Module      : master_bus_if
// Description : Single-outstanding request/done bus between a master and a
//               memory slave. Master holds bstart and addr until bdone.
// Revision    : 1.0 - initial release
// ============================================================================
interface master_bus_if;
    import rv_core_pkg::*;

    logic        breq;
    logic        bstart;
    ttype_e      ttype;
    tsize_e      tsize;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        bdone;
    logic [31:0] rdata;

    modport master (
        output breq, bstart, ttype, tsize, addr, wdata,
        input  bdone, rdata
    );

    modport slave (
        input  breq, bstart, ttype, tsize, addr, wdata,
        output bdone, rdata
    );

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with synchronous flush and entry count.
//               The caller guarantees no push when full and no pop when
//               empty; the FIFO itself does not check.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             flush,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] head,
    output logic      [AW:0]      count,
    output logic                  empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    // Pointer and count update; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= push_data;
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/rv_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : rv_prefetch
// Description : Decoupled instruction prefetcher. Issues one word read at a
//               time, queues {pc, inst} pairs and hands them to decode via
//               valid/ready. Supports redirect-with-squash and a debug halt
//               that only takes effect between transactions.
//               Optional: RV_PREFETCH_BYPASS_EN presents returning data in the
//               same cycle when the queue is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_prefetch
    import rv_core_pkg::*;
#(
    parameter  logic [31:0] INITIAL_PC = 32'h0000_0000,
    parameter  int          DEPTH      = 4,
    localparam int          CW         = $clog2(DEPTH) + 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    master_bus_if.master     ibus,
    output logic             inst_valid,
    output logic [31:0]      inst_data,
    output logic [31:0]      inst_pc,
    input  wire logic        inst_ready,
    input  wire logic        redirect,
    input  wire logic [31:0] redirect_pc,
    input  wire logic        halt,
    output logic             halted,
    output logic [CW-1:0]    occupancy
);

    fetch_state_e r_state;
    logic [31:0]  r_fpc;
    logic         r_bstart;

    fetch_entry_t w_push_entry;
    fetch_entry_t w_head;
    logic [CW-1:0] w_count;
    logic         w_empty;
    logic         w_full;
    logic         w_fetch_ok;
    logic         w_push;
    logic         w_pop;

    // A data beat worth keeping: completed in REQ and not squashed this cycle
    assign w_fetch_ok   = (r_state == REQ) && ibus.bdone && !redirect;
    assign w_full       = (w_count == CW'(DEPTH));
    assign w_push_entry = '{pc: r_fpc, inst: ibus.rdata};

    // Fetch FSM with registered bstart; redirect always retargets fpc, and
    // DROP leaves on any bdone since the squashed beat is thrown away anyway
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_fpc    <= INITIAL_PC;
            r_bstart <= 1'b0;
        end else begin
            if (redirect) begin
                r_fpc <= word_align(redirect_pc);
            end else if ((r_state == REQ) && ibus.bdone) begin
                r_fpc <= r_fpc + 32'd4;
            end

            case (r_state)
                IDLE: begin
                    if (!halt && !redirect && !w_full) begin
                        r_state  <= REQ;
                        r_bstart <= 1'b1;
                    end
                end
                REQ: begin
                    if (ibus.bdone) begin
                        r_state  <= IDLE;
                        r_bstart <= 1'b0;
                    end else if (redirect) begin
                        r_state  <= DROP;
                    end
                end
                DROP: begin
                    if (ibus.bdone) begin
                        r_state  <= IDLE;
                        r_bstart <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_bstart <= 1'b0;
                end
            endcase
        end
    end

    // Queue control and consumer-facing outputs
    always_comb begin
        w_pop      = !w_empty && inst_ready && !redirect;
        w_push     = w_fetch_ok;
        inst_valid = !w_empty;
        inst_pc    = w_head.pc;
        inst_data  = w_empty ? NOP : w_head.inst;
`ifdef RV_PREFETCH_BYPASS_EN
        // Empty queue: forward the returning beat straight to decode and
        // skip the queue entirely if it is taken in the same cycle
        if (w_empty && w_fetch_ok) begin
            inst_valid = 1'b1;
            inst_pc    = r_fpc;
            inst_data  = ibus.rdata;
            w_push     = !inst_ready;
        end
`endif
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count),
        .empty     (w_empty)
    );

    assign occupancy   = w_count;
    assign halted      = halt && (r_state == IDLE);

    assign ibus.breq   = 1'b1;
    assign ibus.bstart = r_bstart;
    assign ibus.ttype  = READ;
    assign ibus.tsize  = WORD;
    assign ibus.wdata  = 32'h0;
    assign ibus.addr   = r_fpc;

endmodule
`default_nettype wire

// File: tb/tb_rv_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_prefetch
// Description : Directed self-checking bench for rv_prefetch with a simple
//               programmable-latency memory slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_prefetch;
    import rv_core_pkg::*;

    localparam int DEPTH = 4;
`ifdef RV_PREFETCH_BYPASS_EN
    localparam int FIRST_LAT = 2;
`else
    localparam int FIRST_LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt = 1'b0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        halted;
    logic [2:0]  occupancy;

    int checks = 0;
    int failures = 0;

    master_bus_if bus();

    rv_prefetch #(
        .INITIAL_PC (32'h0000_0100),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ibus        (bus),
        .inst_valid  (inst_valid),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .halted      (halted),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    // Memory contents as a pure function of address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // Slave: bdone 'lat' cycles after it first sees bstart, data sampled then
    int lat = 1;
    int cnt = 0;
    always @(posedge clk) begin
        bus.bdone <= 1'b0;
        if (rst || !bus.bstart) begin
            cnt <= 0;
        end else if (!bus.bdone) begin
            if (cnt >= lat - 1) begin
                bus.bdone <= 1'b1;
                bus.rdata <= mem_word(bus.addr);
                cnt       <= 0;
            end else begin
                cnt <= cnt + 1;
            end
        end
    end

    // Transaction monitor: counts bstart rising edges, remembers the address
    int          tx_count = 0;
    logic [31:0] last_addr = 32'h0;
    logic        prev_bstart = 1'b0;
    always @(posedge clk) begin
        prev_bstart <= bus.bstart;
        if (rst) begin
            tx_count <= 0;
        end else if (bus.bstart && !prev_bstart) begin
            tx_count  <= tx_count + 1;
            last_addr <= bus.addr;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait (bounded) for a valid head, check it, then let the handshake occur
    task automatic recv(input logic [31:0] exp_pc);
        int t = 0;
        while (!inst_valid && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!inst_valid) begin
            checks++;
            failures++;
            $display("FAIL recv_timeout actual=no_valid required=pc_%h", exp_pc);
        end else begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst_data", inst_data, mem_word(exp_pc));
        end
        @(negedge clk);
    endtask

    task automatic pulse_redirect(input logic [31:0] rpc);
        redirect    = 1'b1;
        redirect_pc = rpc;
        @(negedge clk);
        redirect    = 1'b0;
        chk("redirect_valid_drop", 32'(inst_valid), 32'd0);
    endtask

    task automatic wait_bstart();
        int t = 0;
        while (!bus.bstart && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("bstart_seen", 32'(bus.bstart), 32'd1);
    endtask

    typedef struct {
        bit          use_redir;
        logic [31:0] rpc;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic [31:0] pc2;
    } seq_t;

    seq_t tbl[3];

    initial begin
        int n;
        int t0;

        tbl[0] = '{1'b0, 32'h0000_0000, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
        tbl[1] = '{1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        tbl[2] = '{1'b1, 32'h0000_3001, 32'h0000_3000, 32'h0000_3004, 32'h0000_3008};

        // Reset state
        halt = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_halted_hi", 32'(halted), 32'd1);
        halt = 1'b0;
        @(negedge clk);
        chk("rst_halted_lo", 32'(halted), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_bstart", 32'(bus.bstart), 32'd0);
        chk("rst_inst_data_nop", inst_data, NOP);
        chk("bus_breq", 32'(bus.breq), 32'd1);
        chk("bus_ttype", 32'(bus.ttype), 32'(READ));
        chk("bus_tsize", 32'(bus.tsize), 32'(WORD));
        chk("bus_wdata", bus.wdata, 32'h0);

        // Sequential fetch, first-valid latency, redirects incl. address wrap
        lat        = 1;
        inst_ready = 1'b1;
        rst        = 1'b0;
        n = 0;
        while (!inst_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("first_valid_latency", 32'(n), 32'(FIRST_LAT));
        for (int i = 0; i < 3; i++) begin
            if (tbl[i].use_redir) pulse_redirect(tbl[i].rpc);
            recv(tbl[i].pc0);
            recv(tbl[i].pc1);
            recv(tbl[i].pc2);
        end

        // Backpressure: queue fills to DEPTH, then one pop frees one slot
        inst_ready = 1'b0;
        lat        = 1;
        do_reset();
        repeat (40) @(negedge clk);
        chk("full_tx_count", 32'(tx_count), 32'd4);
        chk("full_occupancy", 32'(occupancy), 32'd4);
        chk("full_bstart", 32'(bus.bstart), 32'd0);
        chk("full_head_pc", inst_pc, 32'h0000_0100);
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        chk("pop_occupancy", 32'(occupancy), 32'd3);
        repeat (20) @(negedge clk);
        chk("refill_tx_count", 32'(tx_count), 32'd5);
        chk("refill_addr", last_addr, 32'h0000_0110);
        chk("refill_occupancy", 32'(occupancy), 32'd4);
        chk("refill_bstart", 32'(bus.bstart), 32'd0);

        // Redirect while REQ is outstanding on a 3-cycle slave
        inst_ready = 1'b1;
        lat        = 3;
        do_reset();
        wait_bstart();
        pulse_redirect(32'h0000_2002);
        chk("drop_bstart_held", 32'(bus.bstart), 32'd1);
        recv(32'h0000_2000);
        chk("redirect_addr", last_addr, 32'h0000_2000);
        recv(32'h0000_2004);

        // Redirect coinciding with bdone and a pop
        inst_ready = 1'b0;
        lat        = 1;
        do_reset();
        n = 0;
        while (!(bus.bdone && inst_valid) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("coincide_setup", 32'(bus.bdone && inst_valid), 32'd1);
        inst_ready = 1'b1;
        pulse_redirect(32'h0000_4000);
        chk("coincide_occupancy", 32'(occupancy), 32'd0);
        recv(32'h0000_4000);
        recv(32'h0000_4004);

        // Halt raised mid-transaction
        inst_ready = 1'b0;
        lat        = 3;
        do_reset();
        wait_bstart();
        halt = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            chk("halt_inflight_halted", 32'(halted), 32'd0);
            n++;
        end while (!bus.bdone && n < 20);
        @(negedge clk);
        chk("halt_done_halted", 32'(halted), 32'd1);
        t0 = tx_count;
        repeat (10) @(negedge clk);
        chk("halt_no_new_tx", 32'(tx_count), 32'(t0));
        chk("halt_bstart", 32'(bus.bstart), 32'd0);
        chk("halt_occupancy", 32'(occupancy), 32'd1);
        inst_ready = 1'b1;
        recv(32'h0000_0100);
        chk("halt_drained", 32'(occupancy), 32'd0);
        chk("halt_still_halted", 32'(halted), 32'd1);
        halt = 1'b0;
        recv(32'h0000_0104);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
